// File: rtl/risc_v_pc_gen.sv
// risc_v_pc_gen: fetch-stage PC generator with trap/redirect priority, single-outstanding fetch, stall and sticky halt.
// Optional `RISC_V_PC_PERF_EN adds a 32-bit stall_cycles counter output.
module risc_v_pc_gen #(
  parameter int                    ADDR_WIDTH   = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0,
  parameter logic [ADDR_WIDTH-1:0] TRAP_VECTOR  = 'h100,
  parameter int                    INSTR_BYTES  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  input  logic                  trap_valid,
  input  logic                  halt,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [ADDR_WIDTH-1:0] imem_req_addr,
  input  logic                  imem_rsp_valid,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic                  fetch_kill,
  output logic                  misaligned_err,
  output logic                  halted
`ifdef RISC_V_PC_PERF_EN
  ,
  output logic [31:0]           stall_cycles
`endif
);
  localparam logic [2:0] BOOT   = 3'd0;
  localparam logic [2:0] REQ    = 3'd1;
  localparam logic [2:0] WAIT   = 3'd2;
  localparam logic [2:0] STALL  = 3'd3;
  localparam logic [2:0] HALTED = 3'd4;
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(INSTR_BYTES - 1);
  logic [2:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d, pend_pc_q, pend_pc_d, tgt;
  logic                  pend_q, pend_d, pend_trap_q, pend_trap_d, err_q, err_d;
  logic                  upd, live, cap, trap_sel, redir_sel, mis, resume;
  always_comb begin
    upd       = (state_q == WAIT && imem_rsp_valid && en) || (state_q == STALL && en);
    live      = state_q == REQ || state_q == WAIT || state_q == STALL;
    cap       = live && !upd && (trap_valid || redirect_valid);
    trap_sel  = trap_valid || (pend_q && pend_trap_q);
    redir_sel = redirect_valid || pend_q;
    tgt       = redirect_valid ? redirect_pc : pend_pc_q;
    mis       = !trap_sel && redir_sel && |(tgt & ALIGN_MASK);
    pc_d      = !upd ? pc_q :
                (trap_sel || mis) ? TRAP_VECTOR :
                redir_sel ? tgt : pc_q + ADDR_WIDTH'(INSTR_BYTES);
    err_d     = err_q || (upd && mis);
    pend_d      = upd ? 1'b0 : (cap || pend_q);
    pend_trap_d = upd ? 1'b0 : ((cap && trap_valid) || pend_trap_q);
    // A pending trap makes any later redirect target irrelevant, so freeze it.
    pend_pc_d   = (cap && !trap_valid && !(pend_q && pend_trap_q)) ? redirect_pc : pend_pc_q;
    resume    = halt ? 1'b1 : 1'b0;
    state_d   = state_q == BOOT  ? REQ :
                state_q == REQ   ? (imem_req_ready ? WAIT : halt ? HALTED : REQ) :
                state_q == WAIT  ? (!imem_rsp_valid ? WAIT : !en ? STALL : resume ? HALTED : REQ) :
                state_q == STALL ? (!en ? STALL : resume ? HALTED : REQ) : HALTED;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= BOOT;
      pc_q        <= RESET_VECTOR;
      pend_q      <= 1'b0;
      pend_trap_q <= 1'b0;
      pend_pc_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      pend_q      <= pend_d;
      pend_trap_q <= pend_trap_d;
      pend_pc_q   <= pend_pc_d;
      err_q       <= err_d;
    end
  end
  assign imem_req_valid = state_q == REQ;
  assign imem_req_addr  = pc_q;
  assign pc             = pc_q;
  assign fetch_kill     = state_q == WAIT && imem_rsp_valid && (pend_q || trap_valid || redirect_valid);
  assign misaligned_err = err_q;
  assign halted         = state_q == HALTED;
`ifdef RISC_V_PC_PERF_EN
  logic [31:0] stall_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) stall_q <= '0;
    else if (state_q == STALL || (state_q == REQ && !imem_req_ready)) stall_q <= stall_q + 32'd1;
  end
  assign stall_cycles = stall_q;
`endif
endmodule

// File: doc/risc_v_pc_gen.md
Name: risc_v_pc_gen

Overview:
Parametrised program-counter generator for the RISC-V core's fetch stage. Owns the PC register and selects the next PC by priority: trap, then redirect, then sequential. Drives a single-outstanding valid/ready fetch request to instruction memory. Supports stall, sticky halt and misalignment trapping.

Parameters:
ADDR_WIDTH, 32, width of PC and all address ports
RESET_VECTOR, {ADDR_WIDTH{1'b0}}, PC value loaded on reset
TRAP_VECTOR, 'h100, PC loaded on trap or on a misaligned target
INSTR_BYTES, 4, sequential increment in bytes; must be 2 or 4. The alignment check uses log2(INSTR_BYTES) low bits.

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high
en  input  1  advance enable; 0 = pipeline stall
redirect_valid  input  1  branch/jump redirect request
redirect_pc  input  ADDR_WIDTH  redirect target
trap_valid  input  1  trap request; overrides redirect
halt  input  1  stop fetching after the current update
imem_req_valid  output  1  fetch request valid
imem_req_ready  input  1  memory accepts request
imem_req_addr  output  ADDR_WIDTH  fetch address (= pc)
imem_rsp_valid  input  1  fetch response returned
pc  output  ADDR_WIDTH  current PC
fetch_kill  output  1  current response belongs to a redirected path; decode must discard it
misaligned_err  output  1  sticky; a misaligned target was seen
halted  output  1  FSM is in HALTED

Behaviour:
- Reset is asynchronous, active-high. Reset values:
  - pc=RESET_VECTOR; state=BOOT
  - imem_req_valid, fetch_kill, misaligned_err, halted = 0
  - pending register cleared
- Reset asserted mid-operation aborts any in-flight request. A response arriving in BOOT is ignored.
- FSM states: BOOT, REQ, WAIT, STALL, HALTED.
  - BOOT: always goes to REQ on the next cycle. Gives one idle cycle after reset.
  - REQ: imem_req_valid=1 and imem_req_addr=pc.
    - Address and valid stay stable until imem_req_ready=1.
    - valid && ready moves to WAIT.
    - halt=1 sampled while still in REQ before acceptance moves to HALTED with no request issued.
  - WAIT: imem_req_valid=0. On imem_rsp_valid, an update point occurs if en=1, then go to REQ (or HALTED if halt=1). If en=0, go to STALL.
  - STALL: on en=1, an update point occurs, then go to REQ (or HALTED if halt=1).
  - HALTED: imem_req_valid=0 and pc frozen. Only reset exits.
- Pending register:
  - trap_valid or redirect_valid in any cycle that is not an update point is captured into pending (flag, target, is_trap).
  - A later trap overwrites a pending redirect.
  - A later redirect overwrites a pending redirect but never a pending trap.
  - Pending is cleared at the update point.
- Next-PC priority at an update point:
  - live trap or pending trap → TRAP_VECTOR
  - else live redirect → redirect_pc
  - else pending redirect → pending target
  - else pc + INSTR_BYTES, wrapping modulo 2^ADDR_WIDTH
- Misalignment: if the selected redirect target has nonzero low log2(INSTR_BYTES) bits, pc loads TRAP_VECTOR and misaligned_err is set. misaligned_err stays set until reset.
- fetch_kill = imem_rsp_valid && (pending flag || trap_valid || redirect_valid). It is combinational.
- PC latency: the new pc is visible the cycle after the update point. The request carrying it is presented in that same cycle (REQ).
- Out-of-protocol inputs: redirect/trap are ignored in HALTED and BOOT. imem_rsp_valid is ignored outside WAIT.

Optional Feature:
RISC_V_PC_PERF_EN
- Defined: adds output stall_cycles [31:0], reset to 0. It increments (wrapping) on every cycle in STALL, and every cycle in REQ with imem_req_ready=0.
- Undefined: the port and the counter do not exist. All other behaviour is identical.

Test Plan:
- Reset, RESET_VECTOR=0, ready=1, response 1 cycle after each accept, en=1 → imem_req_addr sequence 0x0,0x4,0x8; after BOOT, one request every 2 cycles.
- pc=0xFFFFFFFC with a sequential update → pc=0x00000000 (wrap); misaligned_err stays 0.
- redirect_valid with redirect_pc=0x200 during WAIT, response next cycle → fetch_kill=1 on that response; next imem_req_addr=0x200.
- trap_valid and redirect_valid (0x300) in the same WAIT cycle → next pc=0x100 (TRAP_VECTOR); a redirect alone to 0x302 → pc=0x100 and misaligned_err=1 sticky.
- Response arrives with en=0 for 3 cycles → FSM in STALL, pc unchanged, no request; en=1 → pc+4. With RISC_V_PC_PERF_EN, stall_cycles=3.
- halt=1 at an update point with pc=0x40 → pc=0x44, halted=1, no further requests; assert reset mid-WAIT → pc=RESET_VECTOR, halted=0, state BOOT.
